// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared constants and state encoding
// for the multicycle signed divider.
package div_unit_pkg;

  localparam int WORD     = 32;
  localparam int DIV_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring-division
// iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0] sh;
  logic [WIDTH:0] diff;

  assign sh   = {rem, quo[WIDTH-1]};
  assign diff = sh - {1'b0, dvs};

  // A borrow out of the wide subtract means sh < dvs: restore.
  always_comb begin
    rem_n = sh[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_n = diff[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multicycle signed divider, HI = remainder,
// LO = quotient, 33 cycles from start to done.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(DIV_ITER);

  state_t           state;
  state_t           state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic             sign_q;
  logic             sign_r;
  logic             go;

  assign go = start && (divisor != '0);

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem   (rem),
    .quo   (quo),
    .dvs   (dvs),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (go) state_d = CALC;
      CALC:    if (cnt == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && divisor == '0) div_zero <= 1'b1;
          if (go) begin
            rem    <= '0;
            quo    <= dividend[WIDTH-1] ? -dividend : dividend;
            dvs    <= divisor[WIDTH-1] ? -divisor : divisor;
            sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r <= dividend[WIDTH-1];
            cnt    <= CW'(DIV_ITER - 1);
            busy   <= 1'b1;
          end
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          lo   <= sign_q ? -quo : quo;
          hi   <= sign_r ? -rem : rem;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit results,
// timing, divide-by-zero, reset and busy-start.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge; returns one negedge after the done pulse.
  task automatic run_div(input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] elo,
                         input logic [31:0] ehi, input bit poke);
    int n;
    int nb;
    bit dz;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = 32'hdead_beef;
    divisor  = 32'h0;
    n  = 0;
    nb = 0;
    dz = 1'b0;
    while (!done && n < 100) begin
      if (busy) nb++;
      if (div_zero) dz = 1'b1;
      if (poke && n == 5) begin
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_hi"}, hi, ehi);
    chk({tag, "_busycyc"}, nb, 32'd33);
    chk({tag, "_busyoff"}, {31'b0, busy}, 32'd0);
    chk({tag, "_dz"}, {31'b0, dz}, 32'd0);
    @(negedge clk);
    chk({tag, "_donepulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_flags", {29'b0, busy, done, div_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    run_div("dm7_2", 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    run_div("d7_m2", 32'd7, 32'hFFFF_FFFE,
            32'hFFFF_FFFD, 32'd1, 1'b0);
    run_div("dmin_m1", 32'h8000_0000, 32'hFFFF_FFFF,
            32'h8000_0000, 32'd0, 1'b0);
    run_div("d9_4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    // Divide by zero: one-cycle flag, nothing else moves.
    start    = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd0;
    @(negedge clk);
    start = 1'b0;
    chk("dz_flag", {31'b0, div_zero}, 32'd1);
    chk("dz_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    chk("dz_pulse", {31'b0, div_zero}, 32'd0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (done || busy) seen = 1'b1;
        @(negedge clk);
      end
      chk("dz_nodone", {31'b0, seen}, 32'd0);
    end
    chk("dz_hi", hi, 32'd1);
    chk("dz_lo", lo, 32'd2);

    // Reset in the 10th CALC cycle.
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_hi", hi, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    chk("mrst_flags", {29'b0, busy, done, div_zero}, 32'd0);
    @(negedge clk);

    run_div("d0_5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0);
    run_div("poke", 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
